// File: rtl/commit_arbiter_if.sv
// Requester-to-arbiter result bus plus the registered ROB commit ports.
// slave: the arbiter side; master: the requester/ROB side.
// No backpressure on commit ports; requesters hold valid/dst/data until req_ready.
interface commit_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_W       = 6,
  parameter int DATA_W       = 64
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*PREG_W-1:0]      req_dst;
  logic [NUM_REQ*DATA_W-1:0]      req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [COMMIT_WIDTH-1:0]        commit_valid;
  logic [COMMIT_WIDTH*PREG_W-1:0] commit_dst;
  logic [COMMIT_WIDTH*DATA_W-1:0] commit_data;

  modport slave (
    input  req_valid, req_dst, req_data,
    output req_ready, commit_valid, commit_dst, commit_data
  );

  modport master (
    output req_valid, req_dst, req_data,
    input  req_ready, commit_valid, commit_dst, commit_data
  );
endinterface

// File: rtl/commit_arbiter.sv
// Round-robin arbiter granting up to COMMIT_WIDTH result requesters onto the ROB commit ports.
// Latency: req_ready combinational in cycle n, commit ports registered in cycle n+1.
// Backpressure: requesters stall until req_ready; the commit side is never stalled.
module commit_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_W       = 6,
  parameter int DATA_W       = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  commit_arbiter_if.slave            bus,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [31:0]                grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

  logic [NUM_REQ-1:0]             ready_c;
  logic [COMMIT_WIDTH-1:0]        slot_vld;
  logic [COMMIT_WIDTH*PREG_W-1:0] slot_dst;
  logic [COMMIT_WIDTH*DATA_W-1:0] slot_data;
  logic [CNT_W-1:0]               n_gnt;
  logic [IDX_W-1:0]               last_idx;
  logic [IDX_W-1:0]               idx;
  logic [32:0]                    cnt_sum;
  logic [31:0]                    cnt_next;

  // Scan from rr_ptr; the j-th valid requester found lands in slot j. Unused slots stay zero.
  always_comb begin
    ready_c   = '0;
    slot_vld  = '0;
    slot_dst  = '0;
    slot_data = '0;
    n_gnt     = '0;
    last_idx  = rr_ptr;
    idx       = rr_ptr;
    if (!reset && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = rr_ptr + IDX_W'(k);
        if (bus.req_valid[idx] && (n_gnt < CNT_W'(COMMIT_WIDTH))) begin
          ready_c[idx] = 1'b1;
          for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (n_gnt == CNT_W'(j)) begin
              slot_vld[j]                   = 1'b1;
              slot_dst[j*PREG_W +: PREG_W]  = bus.req_dst[idx*PREG_W +: PREG_W];
              slot_data[j*DATA_W +: DATA_W] = bus.req_data[idx*DATA_W +: DATA_W];
            end
          end
          last_idx = idx;
          n_gnt    = n_gnt + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = ready_c;

  always_comb begin
    cnt_sum  = {1'b0, grant_cnt} + 33'(n_gnt);
    cnt_next = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.commit_valid <= '0;
      bus.commit_dst   <= '0;
      bus.commit_data  <= '0;
      rr_ptr           <= '0;
      grant_cnt        <= '0;
    end else if (flush) begin
      bus.commit_valid <= '0;
      bus.commit_dst   <= '0;
      bus.commit_data  <= '0;
      rr_ptr           <= '0;
    end else begin
      bus.commit_valid <= slot_vld;
      bus.commit_dst   <= slot_dst;
      bus.commit_data  <= slot_data;
      if (n_gnt != '0) begin
        rr_ptr <= last_idx + 1'b1;
      end
      grant_cnt <= cnt_next;
    end
  end

  a_ready_implies_valid: assert property (@(posedge clk) disable iff (reset)
    (bus.req_ready & ~bus.req_valid) == '0);

  a_grant_bound: assert property (@(posedge clk) disable iff (reset)
    $countones(bus.req_ready) <= COMMIT_WIDTH);

  a_flush_no_grant: assert property (@(posedge clk) disable iff (reset)
    flush |-> (bus.req_ready == '0));

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed and randomized-traffic bench for commit_arbiter with NUM_REQ=4, COMMIT_WIDTH=2.
module tb_commit_arbiter;
  localparam int NR = 4;
  localparam int CW = 2;
  localparam int PW = 6;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  rr_ptr;
  logic [31:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] dst_q [NR];
  logic [DW-1:0] dat_q [NR];
  logic [NR-1:0] vld_q;

  commit_arbiter_if #(.NUM_REQ(NR), .COMMIT_WIDTH(CW), .PREG_W(PW), .DATA_W(DW)) bus ();

  commit_arbiter #(.NUM_REQ(NR), .COMMIT_WIDTH(CW), .PREG_W(PW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .rr_ptr    (rr_ptr),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = vld_q;
    for (int i = 0; i < NR; i++) begin
      bus.req_dst[i*PW +: PW]  = dst_q[i];
      bus.req_data[i*DW +: DW] = dat_q[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v, input logic [11:0] d,
                         input logic [127:0] dat, input logic [1:0] rr, input logic [31:0] gc);
    chk({tag, "_vld"},  128'(bus.commit_valid), 128'(v));
    chk({tag, "_dst"},  128'(bus.commit_dst),   128'(d));
    chk({tag, "_data"}, bus.commit_data,        dat);
    chk({tag, "_rr"},   128'(rr_ptr),           128'(rr));
    chk({tag, "_gcnt"}, 128'(grant_cnt),        128'(gc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Stress-model state
  int            m_rr;
  int            m_cnt;
  int            n;
  int            last;
  int            ii;
  logic [NR-1:0] m_rdy;
  logic [NR-1:0] rdy;
  logic [1:0]    e_vld;
  logic [11:0]   e_dst;
  logic [127:0]  e_dat;
  logic [1:0]    x_vld;
  logic [11:0]   x_dst;
  logic [127:0]  x_dat;
  int            wait_c [NR];
  logic          starved;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    vld_q = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      dst_q[i] = PW'(8'h10 + i);
      dat_q[i] = 64'hA000 + 64'(i);
    end
    drive();

    cyc(); #1;
    chk("rst_ready", 128'(bus.req_ready), 128'h0);
    cyc();
    chk_out("rst", 2'b00, 12'h0, 128'h0, 2'd0, 32'd0);

    // All four valid for two cycles
    reset = 1'b0;
    #1 chk("c1_ready", 128'(bus.req_ready), 128'b0011);
    cyc();
    chk_out("c2", 2'b11, {6'h11, 6'h10}, {64'hA001, 64'hA000}, 2'd2, 32'd2);
    #1 chk("c2_ready", 128'(bus.req_ready), 128'b1100);
    cyc();
    chk_out("c3", 2'b11, {6'h13, 6'h12}, {64'hA003, 64'hA002}, 2'd0, 32'd4);

    // Single valid requester
    vld_q    = 4'b0100;
    dst_q[2] = 6'h15;
    dat_q[2] = 64'hDEAD;
    drive();
    #1 chk("single_ready", 128'(bus.req_ready), 128'b0100);
    cyc();
    chk_out("single", 2'b01, 12'h015, {64'h0, 64'hDEAD}, 2'd3, 32'd5);
    vld_q = 4'b0000;
    drive();
    #1 chk("idle_ready", 128'(bus.req_ready), 128'h0);
    cyc();
    chk_out("idle", 2'b00, 12'h0, 128'h0, 2'd3, 32'd5);

    // Wrap from rr_ptr=3
    vld_q = 4'b1001;
    drive();
    #1 chk("wrap_ready", 128'(bus.req_ready), 128'b1001);
    cyc();
    // Wrap result is visible during the flush cycle and must survive it
    chk_out("wrap", 2'b11, {6'h10, 6'h13}, {64'hA000, 64'hA003}, 2'd1, 32'd7);
    flush = 1'b1;
    vld_q = 4'b1111;
    drive();
    #1 chk("flush_ready", 128'(bus.req_ready), 128'h0);
    cyc();
    chk_out("post_flush", 2'b00, 12'h0, 128'h0, 2'd0, 32'd7);
    flush = 1'b0;
    #1 chk("post_flush_ready", 128'(bus.req_ready), 128'b0011);
    cyc();
    chk_out("pend", 2'b11, {6'h11, 6'h10}, {64'hA001, 64'hA000}, 2'd2, 32'd9);

    // Reset with traffic in flight
    reset = 1'b1;
    #1 chk("midrst_ready", 128'(bus.req_ready), 128'h0);
    cyc();
    chk_out("midrst", 2'b00, 12'h0, 128'h0, 2'd0, 32'd0);
    reset = 1'b0;
    vld_q = 4'b0000;
    drive();

    // Random traffic against a scan-order reference model
    m_rr  = 0;
    m_cnt = 0;
    m_rdy = '0;
    x_vld = '0;
    x_dst = '0;
    x_dat = '0;
    for (int i = 0; i < NR; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      cyc();
      chk_out("stress", x_vld, x_dst, x_dat, 2'(m_rr), 32'(m_cnt));
      for (int i = 0; i < NR; i++) begin
        if (m_rdy[i] || !vld_q[i]) begin
          vld_q[i] = ($urandom_range(0, 3) != 0);
          dst_q[i] = PW'($urandom);
          dat_q[i] = {$urandom, $urandom};
        end
      end
      drive();
      #1;
      rdy   = '0;
      n     = 0;
      last  = m_rr;
      e_vld = '0;
      e_dst = '0;
      e_dat = '0;
      for (int k = 0; k < NR; k++) begin
        ii = (m_rr + k) % NR;
        if (vld_q[ii] && n < CW) begin
          rdy[ii]             = 1'b1;
          e_vld[n]            = 1'b1;
          e_dst[n*PW +: PW]   = dst_q[ii];
          e_dat[n*DW +: DW]   = dat_q[ii];
          last                = ii;
          n++;
        end
      end
      chk("stress_ready", 128'(bus.req_ready), 128'(rdy));
      starved = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (vld_q[i] && !rdy[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > 1) starved = 1'b1;
      end
      chk("stress_fair", 128'(starved), 128'h0);
      if (n > 0) m_rr = (last + 1) % NR;
      m_cnt = m_cnt + n;
      m_rdy = rdy;
      x_vld = e_vld;
      x_dst = e_dst;
      x_dat = e_dat;
    end
    cyc();
    chk_out("stress_end", x_vld, x_dst, x_dat, 2'(m_rr), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
